// File: rtl/comma_aligner.sv
// comma_aligner: recovers 10b symbol boundaries from the serial receive stream.
// Hunts for a K28.5 comma (either disparity) at any bit offset, confirms it over
// several boundary-aligned commas, then emits framed symbols until lock is lost
// through repeated misaligned commas, electrical idle or reset.
module comma_aligner #(
  parameter int                      SYMBOL_WIDTH = 10,
  parameter logic [SYMBOL_WIDTH-1:0] COMMA_POS    = 10'b0011111010,
  parameter logic [SYMBOL_WIDTH-1:0] COMMA_NEG    = 10'b1100000101,
  parameter int                      LOCK_COUNT   = 3,
  parameter int                      UNLOCK_COUNT = 4
) (
  input  logic                    clock,
  input  logic                    Reset_n,
  input  logic                    data_in,
  input  logic                    RXIDLE,
  output logic [SYMBOL_WIDTH-1:0] symbol_out,
  output logic                    symbol_strobe,
  output logic                    comma_det,
  output logic                    RXVALID,
  output logic                    align_error
);

  // Both counters share one width large enough for either threshold.
  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PH_W    = (SYMBOL_WIDTH > 1) ? $clog2(SYMBOL_WIDTH) : 1;

  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(SYMBOL_WIDTH - 1);
  localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] LOCK_THR   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_THR = CNT_W'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Saturating increment: counters stick at their top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_TOP) ? cnt : cnt + CNT_ONE;
  endfunction

  // Phase advance with wrap at the last bit of a symbol.
  function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] ph);
    return (ph == PH_LAST) ? '0 : ph + PH_ONE;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYMBOL_WIDTH-1:0] r_window_p0;
  logic [PH_W-1:0]         r_phase;
  logic [PH_W-1:0]         w_phase_nxt;
  logic [CNT_W-1:0]        r_match_cnt;
  logic [CNT_W-1:0]        w_match_cnt_nxt;
  logic [CNT_W-1:0]        r_miss_cnt;
  logic [CNT_W-1:0]        w_miss_cnt_nxt;
  logic [CNT_W-1:0]        w_match_inc;
  logic [CNT_W-1:0]        w_miss_inc;
  logic                    w_match;
  logic                    w_boundary;

  logic [SYMBOL_WIDTH-1:0] r_symbol_p1;
  logic [SYMBOL_WIDTH-1:0] w_symbol_nxt;
  logic                    r_vld_p1;
  logic                    w_vld_nxt;
  logic                    r_comma_p1;
  logic                    w_comma_nxt;
  logic                    r_rxvalid_p1;
  logic                    w_rxvalid_nxt;
  logic                    r_align_err_p1;
  logic                    w_align_err_nxt;

  // ---- stage p0: serial window, comma match and boundary flag ----

  // Shift each received bit into the LSB; the first-received bit ends up in the MSB.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_window_p0 <= '0;
    end else begin
      r_window_p0 <= {r_window_p0[SYMBOL_WIDTH-2:0], data_in};
    end
  end

  assign w_match     = (r_window_p0 == COMMA_POS) || (r_window_p0 == COMMA_NEG);
  assign w_boundary  = (r_phase == PH_LAST);
  assign w_match_inc = sat_inc(r_match_cnt);
  assign w_miss_inc  = sat_inc(r_miss_cnt);

  // Next-state, counter and framed-output decisions for the alignment FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = ph_inc(r_phase);
    w_match_cnt_nxt = r_match_cnt;
    w_miss_cnt_nxt  = r_miss_cnt;
    w_symbol_nxt    = r_symbol_p1;
    w_vld_nxt       = 1'b0;
    w_comma_nxt     = 1'b0;
    w_align_err_nxt = 1'b0;

    if (RXIDLE) begin
      // Electrical idle overrides every other event in the same cycle.
      w_state_nxt     = S_HUNT;
      w_phase_nxt     = '0;
      w_match_cnt_nxt = '0;
      w_miss_cnt_nxt  = '0;
    end else begin
      unique case (r_state)
        S_HUNT: begin
          if (w_match) begin
            // Restart the phase so that this match cycle counts as a boundary.
            w_phase_nxt     = '0;
            w_match_cnt_nxt = CNT_ONE;
            w_miss_cnt_nxt  = '0;
            if (CNT_ONE >= LOCK_THR) begin
              w_state_nxt  = S_LOCKED;
              w_symbol_nxt = r_window_p0;
              w_vld_nxt    = 1'b1;
              w_comma_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_VERIFY;
            end
          end
        end

        S_VERIFY: begin
          if (w_match) begin
            if (w_boundary) begin
              w_match_cnt_nxt = w_match_inc;
              if (w_match_inc >= LOCK_THR) begin
                // The locking comma itself is the first framed symbol.
                w_state_nxt    = S_LOCKED;
                w_miss_cnt_nxt = '0;
                w_symbol_nxt   = r_window_p0;
                w_vld_nxt      = 1'b1;
                w_comma_nxt    = 1'b1;
              end
            end else begin
              // A comma at a new offset wins: realign and start counting again.
              w_phase_nxt     = '0;
              w_match_cnt_nxt = CNT_ONE;
            end
          end
        end

        S_LOCKED: begin
          if (w_boundary) begin
            w_symbol_nxt = r_window_p0;
            w_vld_nxt    = 1'b1;
            w_comma_nxt  = w_match;
            if (w_match) begin
              w_miss_cnt_nxt = '0;
            end
          end else if (w_match) begin
            // Misaligned comma: flag it but keep the established phase.
            w_align_err_nxt = 1'b1;
            w_miss_cnt_nxt  = w_miss_inc;
            if (w_miss_inc >= UNLOCK_THR) begin
              w_state_nxt     = S_HUNT;
              w_match_cnt_nxt = '0;
              w_miss_cnt_nxt  = '0;
            end
          end
        end

        default: begin
          w_state_nxt = S_HUNT;
        end
      endcase
    end
  end

  assign w_rxvalid_nxt = (w_state_nxt == S_LOCKED);

  // Alignment FSM state register.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase and comma counters.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_phase     <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_miss_cnt  <= w_miss_cnt_nxt;
    end
  end

  // ---- stage p1: registered framed outputs ----

  // Register the framed symbol, its strobe/comma flags, lock status and error pulse.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_symbol_p1    <= '0;
      r_vld_p1       <= 1'b0;
      r_comma_p1     <= 1'b0;
      r_rxvalid_p1   <= 1'b0;
      r_align_err_p1 <= 1'b0;
    end else begin
      r_symbol_p1    <= w_symbol_nxt;
      r_vld_p1       <= w_vld_nxt;
      r_comma_p1     <= w_comma_nxt;
      r_rxvalid_p1   <= w_rxvalid_nxt;
      r_align_err_p1 <= w_align_err_nxt;
    end
  end

  assign symbol_out    = r_symbol_p1;
  assign symbol_strobe = r_vld_p1;
  assign comma_det     = r_comma_p1;
  assign RXVALID       = r_rxvalid_p1;
  assign align_error   = r_align_err_p1;

endmodule
